// File: rtl/pcpi_pkg.sv
// Shared PCPI definitions: operand width, issuer state encoding and the
// response record also used by the coprocessor compare wrappers.
package pcpi_pkg;

    localparam int PCPI_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } pcpi_state_e;

    typedef struct packed {
        logic [PCPI_XLEN-1:0] rd;
        logic                 wr;
        logic                 illegal;
    } pcpi_rsp_t;

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// Saturating wait-free cycle counter; hit flags the last cycle before a
// PCPI request must be abandoned.
module pcpi_timeout_ctr #(
    parameter int LIMIT = 16,
    parameter int W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    logic [W-1:0] cnt_q, cnt_d;

    // Counter is held at zero outside its enable window so every issue starts fresh.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || clear) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/pcpi_issuer.sv
// PCPI initiator: issues one command to a coprocessor, returns its result.
// Timeout abort is built only when PCPI_ISSUER_TIMEOUT_EN is defined.
module pcpi_issuer
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [PCPI_XLEN-1:0] cmd_insn,
    input  logic [PCPI_XLEN-1:0] cmd_rs1,
    input  logic [PCPI_XLEN-1:0] cmd_rs2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PCPI_XLEN-1:0] rsp_rd,
    output logic                 rsp_wr,
    output logic                 rsp_illegal,
    output logic                 pcpi_valid,
    output logic [PCPI_XLEN-1:0] pcpi_insn,
    output logic [PCPI_XLEN-1:0] pcpi_rs1,
    output logic [PCPI_XLEN-1:0] pcpi_rs2,
    input  logic                 pcpi_wr,
    input  logic [PCPI_XLEN-1:0] pcpi_rd,
    input  logic                 pcpi_wait,
    input  logic                 pcpi_ready
);

    pcpi_state_e          state_q, state_d;
    logic                 pcpi_valid_q, pcpi_valid_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [PCPI_XLEN-1:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d;
    pcpi_rsp_t            rsp_q, rsp_d;
    logic                 timeout_hit;

`ifdef PCPI_ISSUER_TIMEOUT_EN
    logic to_hit;

    pcpi_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (resetn),
        .clear  (pcpi_wait),
        .enable (state_q == ISSUE),
        .hit    (to_hit)
    );

    assign timeout_hit = to_hit && !pcpi_wait;
    assign rsp_illegal = rsp_q.illegal;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{pcpi_wait, rsp_q.illegal, TIMEOUT_CYCLES[0], CNT_W[0]};
    assign timeout_hit = 1'b0;
    assign rsp_illegal = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pcpi_valid_d = pcpi_valid_q;
        rsp_valid_d  = rsp_valid_q;
        insn_d       = insn_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rsp_d        = rsp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    insn_d       = cmd_insn;
                    rs1_d        = cmd_rs1;
                    rs2_d        = cmd_rs2;
                    pcpi_valid_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // A ready in the abort cycle still completes normally.
                if (pcpi_ready) begin
                    rsp_d        = '{rd: pcpi_rd, wr: pcpi_wr, illegal: 1'b0};
                    pcpi_valid_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (timeout_hit) begin
                    rsp_d        = '{rd: '0, wr: 1'b0, illegal: 1'b1};
                    pcpi_valid_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                pcpi_valid_d = 1'b0;
                rsp_valid_d  = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            pcpi_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            insn_q       <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rsp_q        <= '0;
        end else begin
            state_q      <= state_d;
            pcpi_valid_q <= pcpi_valid_d;
            rsp_valid_q  <= rsp_valid_d;
            insn_q       <= insn_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rsp_q        <= rsp_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign pcpi_valid = pcpi_valid_q;
    assign pcpi_insn  = insn_q;
    assign pcpi_rs1   = rs1_q;
    assign pcpi_rs2   = rs2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rd     = rsp_q.rd;
    assign rsp_wr     = rsp_q.wr;

endmodule

// File: tb/tb_pcpi_issuer.sv
// Self-checking bench for pcpi_issuer: scripted scenarios plus randomized
// transactions against a stub coprocessor and a cycle-count reference model.
module tb_pcpi_issuer;

    localparam int T = 16;
`ifdef PCPI_ISSUER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [31:0] MUL_INSN = 32'h02B5_0533;
    localparam logic [31:0] ADD_INSN = 32'h00B5_0533;

    logic        clk, resetn;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
    logic        rsp_valid, rsp_ready, rsp_wr, rsp_illegal;
    logic [31:0] rsp_rd;
    logic        pcpi_valid, pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rd;

    int n_checks = 0;
    int n_fail   = 0;

    pcpi_issuer #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rd(rsp_rd), .rsp_wr(rsp_wr), .rsp_illegal(rsp_illegal),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: responder idles pre_free cycles, waits wait_cyc
    // cycles, then answers (if answer). Abort after T consecutive wait-free
    // cycles without ready; ready on the T-th such cycle still wins.
    function automatic bit exp_abort(input int pre_free, input int wait_cyc, input bit answer);
        if (!TO_EN) return 1'b0;
        return (pre_free >= T) || !answer;
    endfunction

    function automatic int exp_vcyc(input int pre_free, input int wait_cyc, input bit answer);
        if (TO_EN && pre_free >= T) return T;
        if (answer) return pre_free + wait_cyc + 1;
        return (wait_cyc == 0) ? T : pre_free + wait_cyc + T;
    endfunction

    // Presents a command, then plays the stub coprocessor while pcpi_valid is high.
    task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                           input int pre_free, input int wait_cyc, input bit answer,
                           input logic [31:0] rd, input logic wr,
                           output int vcyc, output bit stable);
        int n;
        cmd_valid = 1'b1; cmd_insn = insn; cmd_rs1 = rs1; cmd_rs2 = rs2;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_insn = $urandom; cmd_rs1 = $urandom; cmd_rs2 = $urandom;
        vcyc = 0; stable = 1'b1;
        while (pcpi_valid && vcyc < 400) begin
            if (pcpi_insn !== insn || pcpi_rs1 !== rs1 || pcpi_rs2 !== rs2) stable = 1'b0;
            pcpi_wait  = (vcyc >= pre_free) && (vcyc < pre_free + wait_cyc);
            pcpi_ready = answer && (vcyc == pre_free + wait_cyc);
            pcpi_rd    = pcpi_ready ? rd : $urandom;
            pcpi_wr    = pcpi_ready ? wr : 1'($urandom);
            vcyc++;
            @(negedge clk);
        end
        pcpi_wait = 1'b0; pcpi_ready = 1'b0;
    endtask

    // Samples the response, then consumes it after delay cycles.
    task automatic take_rsp(input int delay, output logic vld, output logic [31:0] rd,
                            output logic wr, output logic ill);
        vld = rsp_valid; rd = rsp_rd; wr = rsp_wr; ill = rsp_illegal;
        repeat (delay) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cmd_valid = 1'b0; cmd_insn = '0; cmd_rs1 = '0; cmd_rs2 = '0; rsp_ready = 1'b0;
        pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || pcpi_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: cmd_ready=%b pcpi_valid=%b rsp_valid=%b, want 1 0 0",
                     cmd_ready, pcpi_valid, rsp_valid);
        end
        n_checks++;
        if (pcpi_insn !== 32'd0 || pcpi_rs1 !== 32'd0 || pcpi_rs2 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_operands: insn=%h rs1=%h rs2=%h, want 0", pcpi_insn, pcpi_rs1, pcpi_rs2);
        end
        n_checks++;
        if (rsp_rd !== 32'd0 || rsp_wr !== 1'b0 || rsp_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: rd=%h wr=%b illegal=%b, want 0 0 0", rsp_rd, rsp_wr, rsp_illegal);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int vc; bit st; logic v, w, il; logic [31:0] rd;
        rsp_ready = 1'b1;
        run_txn(MUL_INSN, 32'd7, 32'd6, 2, 0, 1'b1, 32'd7 * 32'd6, 1'b1, vc, st);
        v = rsp_valid; rd = rsp_rd; w = rsp_wr; il = rsp_illegal;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (v !== 1'b1 || rd !== 32'd42 || w !== 1'b1 || il !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_result: valid=%b rd=%0d wr=%b illegal=%b, want 1 42 1 0", v, rd, w, il);
        end
        n_checks++;
        if (vc !== 3 || st !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_timing: pcpi_valid cycles=%0d stable=%b, want 3 1", vc, st);
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_handshake: rsp_valid=%b cmd_ready=%b, want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_unclaimed();
        int vc, pre; bit st, ans; logic v, w, il; logic [31:0] rd;
        pre = TO_EN ? 0 : 40;
        ans = !TO_EN;
        run_txn(ADD_INSN, 32'd100, 32'd23, pre, 0, ans, 32'h55, 1'b1, vc, st);
        take_rsp(1, v, rd, w, il);
        n_checks++;
        if (vc !== exp_vcyc(pre, 0, ans)) begin
            n_fail++;
            $display("FAIL unclaimed_cycles: got %0d, want %0d", vc, exp_vcyc(pre, 0, ans));
        end
        n_checks++;
        if (v !== 1'b1 || il !== exp_abort(pre, 0, ans) ||
            rd !== (exp_abort(pre, 0, ans) ? 32'd0 : 32'h55) || w !== !exp_abort(pre, 0, ans)) begin
            n_fail++;
            $display("FAIL unclaimed_rsp: valid=%b rd=%h wr=%b illegal=%b, want abort=%b",
                     v, rd, w, il, exp_abort(pre, 0, ans));
        end
    endtask

    task automatic test_long_wait();
        int vc; bit st; logic v, w, il; logic [31:0] rd;
        run_txn(MUL_INSN, 32'd3, 32'd4, 3, 40, 1'b1, 32'hDEADBEEF, 1'b1, vc, st);
        take_rsp(0, v, rd, w, il);
        n_checks++;
        if (v !== 1'b1 || rd !== 32'hDEADBEEF || w !== 1'b1 || il !== 1'b0 || vc !== 44 || st !== 1'b1) begin
            n_fail++;
            $display("FAIL long_wait: valid=%b rd=%h wr=%b illegal=%b cycles=%0d stable=%b, want 1 deadbeef 1 0 44 1",
                     v, rd, w, il, vc, st);
        end
    endtask

    task automatic test_ready_on_abort();
        int vc; bit st; logic v, w, il; logic [31:0] rd;
        run_txn(MUL_INSN, 32'd1, 32'd2, T - 1, 0, 1'b1, 32'h1234, 1'b1, vc, st);
        take_rsp(0, v, rd, w, il);
        n_checks++;
        if (v !== 1'b1 || rd !== 32'h1234 || il !== 1'b0 || vc !== T) begin
            n_fail++;
            $display("FAIL ready_on_abort: valid=%b rd=%h illegal=%b cycles=%0d, want 1 1234 0 %0d",
                     v, rd, il, vc, T);
        end
    endtask

    task automatic test_backpressure();
        int vc; bit st, ok; logic [31:0] r0; logic w0;
        run_txn(MUL_INSN, 32'd11, 32'd12, 1, 0, 1'b1, 32'd132, 1'b1, vc, st);
        r0 = rsp_rd; w0 = rsp_wr;
        cmd_valid = 1'b1; cmd_insn = 32'hA5A5_0033; cmd_rs1 = 32'd9; cmd_rs2 = 32'd8;
        for (int i = 0; i < 5; i++) begin
            ok = (rsp_valid === 1'b1) && (rsp_rd === 32'd132) && (rsp_wr === 1'b1) &&
                 (cmd_ready === 1'b0) && (pcpi_valid === 1'b0) && (rsp_rd === r0) && (rsp_wr === w0);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: rsp_valid=%b rd=%0d cmd_ready=%b pcpi_valid=%b, want 1 132 0 0",
                         i, rsp_valid, rsp_rd, cmd_ready, pcpi_valid);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || pcpi_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: rsp_valid=%b cmd_ready=%b pcpi_valid=%b, want 0 1 0",
                     rsp_valid, cmd_ready, pcpi_valid);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (pcpi_valid !== 1'b1 || pcpi_insn !== 32'hA5A5_0033 || pcpi_rs1 !== 32'd9 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_second: pcpi_valid=%b insn=%h rs1=%0d cmd_ready=%b, want 1 a5a50033 9 0",
                     pcpi_valid, pcpi_insn, pcpi_rs1, cmd_ready);
        end
        pcpi_ready = 1'b1; pcpi_rd = 32'd77; pcpi_wr = 1'b0;
        @(negedge clk);
        pcpi_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rd !== 32'd77 || rsp_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_second_rsp: valid=%b rd=%0d wr=%b, want 1 77 0", rsp_valid, rsp_rd, rsp_wr);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int n, vc; bit st; logic v, w, il; logic [31:0] rd;
        cmd_valid = 1'b1; cmd_insn = MUL_INSN; cmd_rs1 = 32'd9; cmd_rs2 = 32'd9;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pcpi_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: pcpi_valid=%b, want 1", pcpi_valid);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (pcpi_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_drop: pcpi_valid=%b rsp_valid=%b, want 0 0", pcpi_valid, rsp_valid);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || pcpi_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_release: cmd_ready=%b pcpi_valid=%b, want 1 0", cmd_ready, pcpi_valid);
        end
        run_txn(MUL_INSN, 32'd3, 32'd5, 2, 1, 1'b1, 32'd3 * 32'd5, 1'b1, vc, st);
        take_rsp(0, v, rd, w, il);
        n_checks++;
        if (v !== 1'b1 || rd !== 32'd15 || w !== 1'b1 || il !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_mul: valid=%b rd=%0d wr=%b illegal=%b, want 1 15 1 0", v, rd, w, il);
        end
    endtask

    task automatic test_random();
        int vc, pre, wt; bit st, ans, ab; logic v, w, il; logic [31:0] rd, a, b, insn;
        for (int i = 0; i < 24; i++) begin
            a    = $urandom;
            b    = $urandom;
            insn = MUL_INSN ^ {20'd0, 5'($urandom), 7'd0};
            pre  = $urandom_range(0, 20);
            wt   = $urandom_range(0, 8);
            ans  = TO_EN ? 1'($urandom) : 1'b1;
            ab   = exp_abort(pre, wt, ans);
            run_txn(insn, a, b, pre, wt, ans, a * b, 1'b1, vc, st);
            take_rsp($urandom_range(0, 3), v, rd, w, il);
            n_checks++;
            if (v !== 1'b1 || il !== ab || rd !== (ab ? 32'd0 : a * b) || w !== !ab ||
                vc !== exp_vcyc(pre, wt, ans) || st !== 1'b1) begin
                n_fail++;
                $display("FAIL random[%0d]: pre=%0d wait=%0d ans=%b got valid=%b rd=%h wr=%b ill=%b cyc=%0d stable=%b, want rd=%h ill=%b cyc=%0d",
                         i, pre, wt, ans, v, rd, w, il, vc, st, ab ? 32'd0 : a * b, ab, exp_vcyc(pre, wt, ans));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_unclaimed();
        test_long_wait();
        test_ready_on_abort();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pcpi_issuer.md
Name: pcpi_issuer

Overview:
- PCPI initiator that replays core-side PCPI transactions against any PCPI coprocessor (picorv32_mul, opicorv32_mul, compare wraps).
- Accepts a command (insn, rs1, rs2) on a valid/ready stream and drives pcpi_valid with stable operands until the coprocessor answers or times out.
- Returns rd/wr/illegal on a valid/ready response stream.
- Used as the bench and standalone driver for coprocessor equivalence testing.

Parameters:
- TIMEOUT_CYCLES, 16, cycles with pcpi_valid high and pcpi_wait low before abort (picorv32 semantics); legal range 2..255.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  issuer idle, command accepted this cycle if cmd_valid.
- cmd_insn  in  32  instruction word.
- cmd_rs1  in  32  operand 1.
- cmd_rs2  in  32  operand 2.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rd  out  32  captured pcpi_rd; 0 on abort.
- rsp_wr  out  1  captured pcpi_wr; 0 on abort.
- rsp_illegal  out  1  1 = timeout abort, no coprocessor claimed insn.
- pcpi_valid  out  1  PCPI request.
- pcpi_insn  out  32  held instruction.
- pcpi_rs1  out  32  held operand 1.
- pcpi_rs2  out  32  held operand 2.
- pcpi_wr  in  1  coprocessor writes rd.
- pcpi_rd  in  32  coprocessor result.
- pcpi_wait  in  1  coprocessor claims insn, still busy.
- pcpi_ready  in  1  coprocessor done; pcpi_rd/pcpi_wr valid.

Behaviour:
- Clock and reset: one clock clk; reset resetn is asynchronous, active-low.
- Reset values:
  - State IDLE.
  - pcpi_valid=0; pcpi_insn/rs1/rs2=0.
  - rsp_valid=0; rsp_rd=0; rsp_wr=0; rsp_illegal=0.
  - Counter=0.
- Combinational and registered outputs:
  - cmd_ready = (state==IDLE), decoded from the state register only.
  - All other outputs are registered.
- IDLE:
  - cmd_valid&&cmd_ready at edge N: latch insn/rs1/rs2, go to ISSUE.
  - pcpi_valid=1 from cycle N+1.
- ISSUE:
  - pcpi_valid=1; pcpi_insn/rs1/rs2 held stable.
  - Counter increments each cycle pcpi_wait=0; clears to 0 on any cycle pcpi_wait=1.
  - pcpi_ready=1 at edge M:
    - Capture rsp_rd=pcpi_rd, rsp_wr=pcpi_wr, rsp_illegal=0.
    - pcpi_valid=0 and rsp_valid=1 from M+1; go to RESP.
  - Abort: pcpi_ready=0, pcpi_wait=0 and counter==TIMEOUT_CYCLES-1:
    - rsp_illegal=1, rsp_rd=0, rsp_wr=0.
    - pcpi_valid=0 and rsp_valid=1 next cycle; go to RESP.
  - pcpi_ready in the abort cycle takes priority: normal completion.
  - pcpi_rd/pcpi_wr are ignored while pcpi_ready=0.
- RESP:
  - rsp_* held stable until rsp_valid&&rsp_ready; then go to IDLE and clear rsp_valid.
  - cmd_ready=1 the following cycle. No bypass; back-to-back throughput is one command per (latency+2) cycles minimum.
  - pcpi_ready arriving outside ISSUE is ignored.
- Reset mid-operation: pcpi_valid and rsp_valid drop immediately on resetn low; any in-flight transaction is discarded.
- Counter saturates and never wraps.

Optional Feature:
- Macro PCPI_ISSUER_TIMEOUT_EN.
- Defined: timeout abort as above.
- Undefined:
  - No counter logic.
  - ISSUE waits indefinitely for pcpi_ready.
  - rsp_illegal is tied to 0.
  - TIMEOUT_CYCLES and CNT_W are unused.

Decomposition:
- Shared package pcpi_pkg:
  - PCPI_XLEN=32.
  - State encoding IDLE=0, ISSUE=1, RESP=2 (2-bit).
  - Response record {rd[31:0], wr, illegal}, reused by the compare wrappers.
- Sub-module pcpi_timeout_ctr (clear, enable, saturate, hit output), instantiated only under PCPI_ISSUER_TIMEOUT_EN.

Test Plan:
- MUL, rsp_ready held 1:
  - Stimulus: cmd 0x02B50533 (mul a0,a0,a1), rs1=7, rs2=6, against picorv32_mul.
  - Required: rsp_rd=42, rsp_wr=1, rsp_illegal=0; pcpi_valid low the cycle after pcpi_ready.
- Unclaimed insn:
  - Stimulus: cmd 0x00B50533 (add) against the mul unit.
  - Required: no wait/ready; abort after 16 cycles of pcpi_valid; rsp_illegal=1, rsp_rd=0, rsp_wr=0.
- Long wait:
  - Stimulus: stub responder asserts pcpi_wait for 40 cycles, then pcpi_ready with rd=0xDEADBEEF, wr=1.
  - Required: no abort; rsp_rd=0xDEADBEEF.
- Ready on abort cycle:
  - Stimulus: stub asserts pcpi_ready exactly on the 16th wait-free cycle, rd=0x1234.
  - Required: rsp_illegal=0, rsp_rd=0x1234.
- Response backpressure:
  - Stimulus: rsp_ready low 5 cycles after completion, with a second cmd presented.
  - Required: rsp_* stable, cmd_ready=0 throughout; second cmd accepted the cycle after the handshake.
- Async reset in ISSUE:
  - Stimulus: resetn low mid-transaction.
  - Required: pcpi_valid=0 without a clock edge; after release, cmd_ready=1 and the next MUL 3*5 returns 15.
